// File: rtl/ctr_buffer.sv
// Circular store of control transfer records with indexed, one-cycle-latency readout.
// Optional macro CTR_BUFFER_WRPTR_WRITE_EN adds software load of the write pointer.
// Record words: source = {pc[XLEN-1:1], v}, target = XLEN bits, data = CTRDATA_W bits.
module ctr_buffer #(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned CTRDATA_W     = 32,
    parameter int unsigned DEPTH         = 16
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [NrCommitPorts*XLEN-1:0]      source_i,
    input  logic [NrCommitPorts*XLEN-1:0]      target_i,
    input  logic [NrCommitPorts*CTRDATA_W-1:0] data_i,
    input  logic                               freeze_i,
    input  logic                               clear_i,
    input  logic                               rd_req_i,
    input  logic [7:0]                         rd_idx_i,
`ifdef CTR_BUFFER_WRPTR_WRITE_EN
    input  logic                               wrptr_we_i,
    input  logic [$clog2(DEPTH)-1:0]           wrptr_wdata_i,
`endif
    output logic                               rd_valid_o,
    output logic [XLEN-1:0]                    rd_source_o,
    output logic [XLEN-1:0]                    rd_target_o,
    output logic [CTRDATA_W-1:0]               rd_data_o,
    output logic [$clog2(DEPTH)-1:0]           wrptr_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]     wrptr_q, wrptr_d;
    logic [XLEN-1:0]      src_q [DEPTH];
    logic [XLEN-1:0]      src_d [DEPTH];
    logic [XLEN-1:0]      tgt_q [DEPTH];
    logic [XLEN-1:0]      tgt_d [DEPTH];
    logic [CTRDATA_W-1:0] dat_q [DEPTH];
    logic [CTRDATA_W-1:0] dat_d [DEPTH];

    logic                 rd_valid_q, rd_valid_d;
    logic [XLEN-1:0]      rd_src_q, rd_src_d;
    logic [XLEN-1:0]      rd_tgt_q, rd_tgt_d;
    logic [CTRDATA_W-1:0] rd_dat_q, rd_dat_d;

    logic [PTR_W-1:0]     slot [NrCommitPorts];
    logic [PTR_W-1:0]     rec_cnt;
    logic                 ptr_we;
    logic [PTR_W-1:0]     ptr_wdata;
    logic [PTR_W-1:0]     rd_slot;
    logic                 rd_oob;

`ifdef CTR_BUFFER_WRPTR_WRITE_EN
    assign ptr_we    = wrptr_we_i;
    assign ptr_wdata = wrptr_wdata_i;
`else
    assign ptr_we    = 1'b0;
    assign ptr_wdata = '0;
`endif

    // Each valid port takes the slot after the previous valid one; invalid ports consume nothing.
    always_comb begin
        rec_cnt = '0;
        for (int p = 0; p < int'(NrCommitPorts); p++) begin
            slot[p] = wrptr_q + rec_cnt;
            if (source_i[p*XLEN]) begin
                rec_cnt = rec_cnt + PTR_W'(1);
            end
        end
    end

    always_comb begin
        src_d   = src_q;
        tgt_d   = tgt_q;
        dat_d   = dat_q;
        wrptr_d = wrptr_q;
        if (clear_i) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                src_d[e][0] = 1'b0;
            end
            wrptr_d = '0;
        end else if (ptr_we) begin
            wrptr_d = ptr_wdata;
        end else if (!freeze_i) begin
            for (int p = 0; p < int'(NrCommitPorts); p++) begin
                if (source_i[p*XLEN]) begin
                    src_d[slot[p]] = source_i[p*XLEN +: XLEN];
                    tgt_d[slot[p]] = target_i[p*XLEN +: XLEN];
                    dat_d[slot[p]] = data_i[p*CTRDATA_W +: CTRDATA_W];
                end
            end
            wrptr_d = wrptr_q + rec_cnt;
        end
    end

    // Logical index 0 is the slot just behind the write pointer.
    assign rd_slot = wrptr_q - PTR_W'(1) - rd_idx_i[PTR_W-1:0];
    assign rd_oob  = {1'b0, rd_idx_i} >= 9'(DEPTH);

    always_comb begin
        rd_valid_d = rd_req_i;
        rd_src_d   = '0;
        rd_tgt_d   = '0;
        rd_dat_d   = '0;
        if (rd_req_i && !rd_oob) begin
            rd_src_d = src_q[rd_slot];
            rd_tgt_d = tgt_q[rd_slot];
            rd_dat_d = dat_q[rd_slot];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wrptr_q <= '0;
            for (int e = 0; e < int'(DEPTH); e++) begin
                src_q[e] <= '0;
                tgt_q[e] <= '0;
                dat_q[e] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_src_q   <= '0;
            rd_tgt_q   <= '0;
            rd_dat_q   <= '0;
        end else begin
            wrptr_q    <= wrptr_d;
            src_q      <= src_d;
            tgt_q      <= tgt_d;
            dat_q      <= dat_d;
            rd_valid_q <= rd_valid_d;
            rd_src_q   <= rd_src_d;
            rd_tgt_q   <= rd_tgt_d;
            rd_dat_q   <= rd_dat_d;
        end
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_source_o = rd_src_q;
    assign rd_target_o = rd_tgt_q;
    assign rd_data_o   = rd_dat_q;
    assign wrptr_o     = wrptr_q;

endmodule

// File: tb/tb_ctr_buffer.sv
// Directed bench for ctr_buffer: vector table plus hand-written clear/freeze/reset sequences.
module tb_ctr_buffer;

    localparam int NP = 2;
    localparam int XL = 32;
    localparam int DW = 32;
    localparam int DP = 16;

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic [NP*XL-1:0] source_i;
    logic [NP*XL-1:0] target_i;
    logic [NP*DW-1:0] data_i;
    logic           freeze_i, clear_i, rd_req_i;
    logic [7:0]     rd_idx_i;
    logic           rd_valid_o;
    logic [XL-1:0]  rd_source_o, rd_target_o;
    logic [DW-1:0]  rd_data_o;
    logic [3:0]     wrptr_o;
`ifdef CTR_BUFFER_WRPTR_WRITE_EN
    logic           wrptr_we_i;
    logic [3:0]     wrptr_wdata_i;
`endif

    int checks = 0;
    int errors = 0;

    ctr_buffer #(.NrCommitPorts(NP), .XLEN(XL), .CTRDATA_W(DW), .DEPTH(DP)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .source_i(source_i), .target_i(target_i), .data_i(data_i),
        .freeze_i(freeze_i), .clear_i(clear_i),
        .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
`ifdef CTR_BUFFER_WRPTR_WRITE_EN
        .wrptr_we_i(wrptr_we_i), .wrptr_wdata_i(wrptr_wdata_i),
`endif
        .rd_valid_o(rd_valid_o), .rd_source_o(rd_source_o),
        .rd_target_o(rd_target_o), .rd_data_o(rd_data_o), .wrptr_o(wrptr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        frz, clr, v0;
        logic [31:0] pc0;
        logic        v1;
        logic [31:0] pc1;
        logic        req;
        logic [7:0]  idx;
        logic [3:0]  e_wp;
        logic        e_rv, e_v;
        logic [31:0] e_pc;
        logic        e_oob;
    } vec_t;

    vec_t vecs [26];

    function automatic logic [31:0] tgt_of(input logic [31:0] pc);
        return pc + 32'h4;
    endfunction

    function automatic logic [31:0] dat_of(input logic [31:0] pc);
        return ~pc;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic frz, input logic clr, input logic v0, input logic [31:0] pc0,
                         input logic v1, input logic [31:0] pc1, input logic req, input logic [7:0] idx);
        freeze_i = frz;
        clear_i  = clr;
        source_i = {pc1[31:1], v1, pc0[31:1], v0};
        target_i = {tgt_of(pc1), tgt_of(pc0)};
        data_i   = {dat_of(pc1), dat_of(pc0)};
        rd_req_i = req;
        rd_idx_i = idx;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'd0);
    endtask

    task automatic check_resp(input string tag, input logic e_rv, input logic e_v,
                              input logic [31:0] e_pc, input logic e_oob);
        chk({tag, ".rd_valid"}, 64'(rd_valid_o), 64'(e_rv));
        if (e_rv) begin
            chk({tag, ".v"}, 64'(rd_source_o[0]), 64'(e_v));
            if (e_oob) begin
                chk({tag, ".zero"}, {rd_source_o, rd_target_o} | 64'(rd_data_o), 64'h0);
            end else if (e_v) begin
                chk({tag, ".src"}, 64'({rd_source_o[31:1], 1'b0}), 64'(e_pc));
                chk({tag, ".tgt"}, 64'(rd_target_o), 64'(tgt_of(e_pc)));
                chk({tag, ".dat"}, 64'(rd_data_o), 64'(dat_of(e_pc)));
            end
        end
    endtask

    initial begin
        //          frz clr v0  pc0      v1  pc1      req idx    wp  rv  v   pc       oob
        vecs[0]  = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd0,  0,  1, 0, 32'h0,   0};
        vecs[1]  = '{0, 0, 1, 32'h100, 0, 32'h0,   0, 8'd0,  1,  0, 0, 32'h0,   0};
        vecs[2]  = '{0, 0, 1, 32'h200, 0, 32'h0,   0, 8'd0,  2,  0, 0, 32'h0,   0};
        vecs[3]  = '{0, 0, 1, 32'h300, 0, 32'h0,   0, 8'd0,  3,  0, 0, 32'h0,   0};
        vecs[4]  = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd0,  3,  1, 1, 32'h300, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd2,  3,  1, 1, 32'h100, 0};
        vecs[6]  = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd3,  3,  1, 0, 32'h0,   0};
        vecs[7]  = '{0, 0, 0, 32'h0,   1, 32'hC0,  1, 8'd0,  4,  1, 1, 32'h300, 0};
        vecs[8]  = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd0,  4,  1, 1, 32'hC0,  0};
        vecs[9]  = '{1, 0, 1, 32'hEE0, 0, 32'h0,   1, 8'd0,  4,  1, 1, 32'hC0,  0};
        vecs[10] = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd0,  4,  1, 1, 32'hC0,  0};
        vecs[11] = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd20, 4,  1, 0, 32'h0,   1};
        vecs[12] = '{0, 0, 1, 32'h400, 1, 32'h410, 0, 8'd0,  6,  0, 0, 32'h0,   0};
        vecs[13] = '{0, 0, 1, 32'h420, 1, 32'h430, 0, 8'd0,  8,  0, 0, 32'h0,   0};
        vecs[14] = '{0, 0, 1, 32'h440, 1, 32'h450, 0, 8'd0,  10, 0, 0, 32'h0,   0};
        vecs[15] = '{0, 0, 1, 32'h460, 1, 32'h470, 0, 8'd0,  12, 0, 0, 32'h0,   0};
        vecs[16] = '{0, 0, 1, 32'h480, 1, 32'h490, 0, 8'd0,  14, 0, 0, 32'h0,   0};
        vecs[17] = '{0, 0, 1, 32'h80,  0, 32'h0,   0, 8'd0,  15, 0, 0, 32'h0,   0};
        vecs[18] = '{0, 0, 1, 32'hA0,  1, 32'hB0,  0, 8'd0,  1,  0, 0, 32'h0,   0};
        vecs[19] = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd0,  1,  1, 1, 32'hB0,  0};
        vecs[20] = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd1,  1,  1, 1, 32'hA0,  0};
        vecs[21] = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd2,  1,  1, 1, 32'h80,  0};
        vecs[22] = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd3,  1,  1, 1, 32'h490, 0};
        vecs[23] = '{0, 0, 1, 32'hD0,  0, 32'h0,   1, 8'd0,  2,  1, 1, 32'hB0,  0};
        vecs[24] = '{0, 0, 0, 32'h0,   0, 32'h0,   1, 8'd0,  2,  1, 1, 32'hD0,  0};
        vecs[25] = '{0, 1, 1, 32'hEE0, 0, 32'h0,   1, 8'd0,  0,  1, 1, 32'hD0,  0};

        rstn_i = 1'b0;
        idle();
`ifdef CTR_BUFFER_WRPTR_WRITE_EN
        wrptr_we_i    = 1'b0;
        wrptr_wdata_i = 4'd0;
`endif
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset.wrptr", 64'(wrptr_o), 64'd0);
        chk("reset.rd_valid", 64'(rd_valid_o), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk_i);
            drive(vecs[i].frz, vecs[i].clr, vecs[i].v0, vecs[i].pc0,
                  vecs[i].v1, vecs[i].pc1, vecs[i].req, vecs[i].idx);
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d.wrptr", i), 64'(wrptr_o), 64'(vecs[i].e_wp));
            check_resp($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_v, vecs[i].e_pc, vecs[i].e_oob);
        end

        // After the clear every logical index reads invalid.
        for (int i = 0; i < DP; i++) begin
            @(negedge clk_i);
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 8'(i));
            @(posedge clk_i);
            #1;
            chk($sformatf("clr_idx%0d.wrptr", i), 64'(wrptr_o), 64'd0);
            check_resp($sformatf("clr_idx%0d", i), 1'b1, 1'b0, 32'h0, 1'b0);
        end

        // Clear wins over freeze.
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 8'd0);
        @(posedge clk_i);
        #1;
        chk("frzclr.pre_wrptr", 64'(wrptr_o), 64'd1);
        @(negedge clk_i);
        drive(1'b1, 1'b1, 1'b1, 32'h510, 1'b0, 32'h0, 1'b0, 8'd0);
        @(posedge clk_i);
        #1;
        chk("frzclr.wrptr", 64'(wrptr_o), 64'd0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 8'd15);
        @(posedge clk_i);
        #1;
        check_resp("frzclr.rd", 1'b1, 1'b0, 32'h0, 1'b0);

`ifdef CTR_BUFFER_WRPTR_WRITE_EN
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b1, 32'h520, 1'b0, 32'h0, 1'b0, 8'd0);
        wrptr_we_i    = 1'b1;
        wrptr_wdata_i = 4'd9;
        @(posedge clk_i);
        #1;
        chk("ptrwr.wrptr", 64'(wrptr_o), 64'd9);
        @(negedge clk_i);
        wrptr_we_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 8'd0);
        @(posedge clk_i);
        #1;
        check_resp("ptrwr.rd", 1'b1, 1'b0, 32'h0, 1'b0);
`endif

        // Asynchronous reset drops a pending response and the pointer.
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 8'd0);
        @(posedge clk_i);
        #1;
        chk("rstmid.pre_rd_valid", 64'(rd_valid_o), 64'd1);
        idle();
        #1;
        rstn_i = 1'b0;
        #1;
        chk("rstmid.wrptr", 64'(wrptr_o), 64'd0);
        chk("rstmid.rd_valid", 64'(rd_valid_o), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 8'd0);
        @(posedge clk_i);
        #1;
        check_resp("rstmid.rd", 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk_i);
        idle();
        @(posedge clk_i);
        #1;
        chk("idle.rd_valid", 64'(rd_valid_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctr_buffer.md
Name: ctr_buffer

Overview:
- Storage and readout end of the control transfer records (CTR) path.
- Consumes up to NrCommitPorts records per cycle (source/target/data triplets) from the CTR record emitter and writes them into a circular buffer of DEPTH entries.
- Serves indexed reads for the CSR file, which implements indirect access to ctrsource/ctrtarget/ctrdata. Logical index 0 is the newest record.
- Exposes the write pointer for sctrstatus.WRPTR.

Parameters:
CVA6Cfg, config_pkg::cva6_cfg_empty, CVA6 configuration; NrCommitPorts sets the number of record ports.
DEPTH, 16, number of record entries; power of two, 16..256.

Ports:
clk_i  input  1  subsystem clock
rstn_i  input  1  asynchronous reset, active low
source_i  input  NrCommitPorts x ctrsource_rv_t  incoming record sources; source_i[k].v marks port k valid
target_i  input  NrCommitPorts x ctrtarget_rv_t  incoming record targets
data_i  input  NrCommitPorts x ctrdata_rv_t  incoming record data
freeze_i  input  1  sctrstatus.FROZEN; inhibits recording
clear_i  input  1  sctrclr pulse; invalidates all entries
rd_req_i  input  1  read request
rd_idx_i  input  8  logical entry index (0 = newest)
rd_valid_o  output  1  read response valid
rd_source_o  output  ctrsource_rv_t  entry source
rd_target_o  output  ctrtarget_rv_t  entry target
rd_data_o  output  ctrdata_rv_t  entry data
wrptr_o  output  clog2(DEPTH)  physical slot of the next write

Behaviour:
- Reset:
  - wrptr = 0.
  - All entry v bits = 0; entry contents = 0.
  - rd_valid_o = 0; all rd_* data = 0.
- Write (only when freeze_i=0 and clear_i=0):
  - Let k = number of valid ports.
  - Valid ports are packed in ascending port order into slots wrptr, wrptr+1, ... wrptr+k-1, all modulo DEPTH.
  - Port 0 is the oldest record.
  - Invalid ports in between are skipped and consume no slot.
  - wrptr advances by k modulo DEPTH on the next edge.
  - Wrap: oldest entries are silently overwritten. There is no full condition and no backpressure.
  - Example: DEPTH=16, wrptr=15, k=2 → slots 15 and 0 written, wrptr=1.
- Freeze: freeze_i=1 drops all incoming records; wrptr and entries are held.
- Clear:
  - clear_i=1 zeroes every entry v bit and wrptr on the next edge.
  - Records presented in the same cycle are dropped; clear has priority over writes.
  - Clear applies regardless of freeze_i.
- Read latency: 1 cycle. A request in cycle N produces rd_valid_o=1 plus data in cycle N+1. rd_valid_o=0 when there is no request.
- Read address: physical slot = (wrptr - 1 - rd_idx_i) mod DEPTH, using wrptr and contents as they stood at the start of cycle N, i.e. before that cycle's writes or clear.
- rd_idx_i >= DEPTH: response returns all-zero source/target/data (v=0) with rd_valid_o=1.
- Never-written or cleared entries read back with v=0. Their other fields are unspecified and the bench must ignore them.
- Back-to-back reads are allowed every cycle.
- Reset mid-operation: everything returns asynchronously to reset values, and any pending read response is lost.

Optional Feature:
- Macro: CTR_BUFFER_WRPTR_WRITE_EN.
- When defined:
  - Adds ports wrptr_we_i (1) and wrptr_wdata_i (clog2(DEPTH)) for software writes of sctrstatus.WRPTR.
  - wrptr_we_i=1 loads wrptr_wdata_i on the next edge.
  - Priority: clear_i first, then wrptr_we_i, then records. Records in a write cycle are dropped.
  - Entries are not modified.
- When undefined: the ports are absent and wrptr changes only through records, clear or reset.

Test Plan:
- Reset, then read idx 0 → rd_valid_o=1 next cycle, rd_source_o.v=0, wrptr_o=0.
- Single record per cycle: push source pc 0x100, 0x200, 0x300 on port 0 → wrptr_o=3; idx0 reads 0x300, idx2 reads 0x100, idx3 reads v=0.
- Dual-port: port0=0xA0, port1=0xB0 in the same cycle, from wrptr=15 with DEPTH=16 → slot15=0xA0, slot0=0xB0, wrptr_o=1; idx0 reads 0xB0, idx1 reads 0xA0.
- Gap packing: port0 invalid, port1=0xC0 → one slot written, wrptr advances by 1.
- Freeze and clear:
  - freeze_i=1 with a valid record → wrptr unchanged and idx0 unchanged.
  - clear_i=1 together with a valid record → wrptr_o=0 and every index reads v=0.
- Read/write same cycle: read idx0 while pushing 0xD0 → response is the previous newest. The following read of idx0 returns 0xD0. Read idx 20 (DEPTH=16) → all zeros with rd_valid_o=1.
